// File: rtl/wb_select_buf_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_select_buf_if
//  Purpose  : Bus bundle for the write-back source selector: producer
//             handshake with selector/data, consumer handshake with the
//             selected word, illegal-select flag and transfer counter.
//             Optional out_par member when WB_SELECT_PARITY_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
interface wb_select_buf_if #(
   parameter int WIDTH = 32,
   parameter int N_IN  = 8,
   parameter int SEL_W = 4,
   parameter int CNT_W = 16
);
   logic                    in_valid;
   logic                    in_ready;
   logic [SEL_W-1:0]        sel;
   logic [N_IN*WIDTH-1:0]   data_in;
   logic                    out_valid;
   logic                    out_ready;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_sel;
   logic                    sel_err;
   logic                    clr_err;
   logic [CNT_W-1:0]        wb_count;
`ifdef WB_SELECT_PARITY_EN
   logic                    out_par;
`endif

   // Producer/consumer side of the block
   modport master (
      output in_valid, sel, data_in, out_ready, clr_err,
      input  in_ready, out_valid, out_data, out_sel, sel_err, wb_count
`ifdef WB_SELECT_PARITY_EN
      , input out_par
`endif
   );

   // The selector block itself
   modport slave (
      input  in_valid, sel, data_in, out_ready, clr_err,
      output in_ready, out_valid, out_data, out_sel, sel_err, wb_count
`ifdef WB_SELECT_PARITY_EN
      , output out_par
`endif
   );
endinterface
`default_nettype wire

// File: rtl/wb_select_buf.sv
`default_nettype none
// ============================================================================
//  Module   : wb_select_buf
//  Purpose  : Write-back source selector. Picks one of N_IN data words or one
//             of three constants, then buffers the word in a 2-entry
//             valid/ready pipeline (output register + skid register).
//             Flags accepted illegal selectors (sticky) and counts completed
//             output transfers.
//  Options  : WB_SELECT_PARITY_EN adds out_par = ^out_data (registered).
//  Revision : 1.0 - initial release
// ============================================================================
module wb_select_buf #(
   parameter int          WIDTH  = 32,
   parameter int          N_IN   = 8,
   parameter int          SEL_W  = 4,
   parameter int unsigned CONST0 = 227,
   parameter int unsigned CONST1 = 0,
   parameter int unsigned CONST2 = 1,
   parameter int          CNT_W  = 16
) (
   input  wire logic       clk,
   input  wire logic       reset,
   wb_select_buf_if.slave  bus
);
   localparam logic [WIDTH-1:0] c_const0    = WIDTH'(CONST0);
   localparam logic [WIDTH-1:0] c_const1    = WIDTH'(CONST1);
   localparam logic [WIDTH-1:0] c_const2    = WIDTH'(CONST2);
   localparam int unsigned      c_first_bad = N_IN + 3;

   logic [WIDTH-1:0] r_out_data;
   logic [SEL_W-1:0] r_out_sel;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_skid_data;
   logic [SEL_W-1:0] r_skid_sel;
   logic             r_skid_valid;
   logic             r_sel_err;
   logic [CNT_W-1:0] r_wb_count;

   logic [WIDTH-1:0] w_word;
   logic             w_illegal;
   logic             w_accept;
   logic             w_fire;
   logic             w_load_out;
   logic [WIDTH-1:0] w_next_data;
   logic [SEL_W-1:0] w_next_sel;

   // Selector decode: data inputs, constant slots, illegal codes forward word 0
   always_comb begin
      w_word    = bus.data_in[WIDTH-1:0];
      w_illegal = 1'b0;
      if (bus.sel == SEL_W'(N_IN)) begin
         w_word = c_const0;
      end else if (bus.sel == SEL_W'(N_IN + 1)) begin
         w_word = c_const1;
      end else if (bus.sel == SEL_W'(N_IN + 2)) begin
         w_word = c_const2;
      end else if (32'(bus.sel) >= c_first_bad) begin
         w_illegal = 1'b1;
      end else begin
         for (int k = 0; k < N_IN; k++) begin
            if (bus.sel == SEL_W'(k)) begin
               w_word = bus.data_in[k*WIDTH +: WIDTH];
            end
         end
      end
   end

   // Handshake qualifiers; in_ready depends only on the skid register and reset
   always_comb begin
      bus.in_ready = reset && !r_skid_valid;
      w_accept     = bus.in_valid && bus.in_ready;
      w_fire       = r_out_valid && bus.out_ready;
      w_load_out   = !r_out_valid || bus.out_ready;
      // A held skid word is always older than anything arriving this cycle
      w_next_data  = r_skid_valid ? r_skid_data : w_word;
      w_next_sel   = r_skid_valid ? r_skid_sel  : bus.sel;
   end

   // Output register and skid register (FIFO order: skid drains before new data)
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_sel    <= '0;
         r_skid_valid <= 1'b0;
         r_skid_data  <= '0;
         r_skid_sel   <= '0;
      end else if (w_load_out) begin
         if (r_skid_valid || w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_next_data;
            r_out_sel   <= w_next_sel;
         end else begin
            r_out_valid <= 1'b0;
         end
         r_skid_valid <= 1'b0;
      end else if (w_accept) begin
         r_skid_valid <= 1'b1;
         r_skid_data  <= w_word;
         r_skid_sel   <= bus.sel;
      end
   end

   // Sticky illegal-select flag; a same-cycle set beats clear
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sel_err <= 1'b0;
      end else if (w_accept && w_illegal) begin
         r_sel_err <= 1'b1;
      end else if (bus.clr_err) begin
         r_sel_err <= 1'b0;
      end
   end

   // Completed-transfer counter, wraps naturally
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wb_count <= '0;
      end else if (w_fire) begin
         r_wb_count <= r_wb_count + CNT_W'(1);
      end
   end

`ifdef WB_SELECT_PARITY_EN
   logic r_out_par;

   // Parity tracks whatever word is loaded into the output register
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_out_par <= 1'b0;
      end else if (w_load_out && (r_skid_valid || w_accept)) begin
         r_out_par <= ^w_next_data;
      end
   end

   assign bus.out_par = r_out_par;
`endif

   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_sel   = r_out_sel;
   assign bus.sel_err   = r_sel_err;
   assign bus.wb_count  = r_wb_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_select_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_select_buf
//  Purpose  : Self-checking bench for wb_select_buf (CNT_W=4 to reach wrap).
//             Reference model: a 2-deep FIFO of selected words, in_ready
//             while fewer than two are held, head visible on the output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_select_buf;
   localparam int WIDTH = 32;
   localparam int N_IN  = 8;
   localparam int SEL_W = 4;
   localparam int CNT_W = 4;

   typedef struct packed {
      logic [WIDTH-1:0] d;
      logic [SEL_W-1:0] s;
   } ent_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   wb_select_buf_if #(.WIDTH(WIDTH), .N_IN(N_IN), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

   wb_select_buf #(
      .WIDTH(WIDTH), .N_IN(N_IN), .SEL_W(SEL_W),
      .CONST0(227), .CONST1(0), .CONST2(1), .CNT_W(CNT_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int               tests = 0;
   int               fails = 0;
   logic [WIDTH-1:0] words [N_IN];
   int               ov_k  = -1;
   logic [WIDTH-1:0] ov_v;
   ent_t             q [$];
   bit               m_err;
   int               m_cnt;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp)
      else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] ref_word(input int s);
      if (s < N_IN)      return words[s];
      if (s == N_IN)     return 32'd227;
      if (s == N_IN + 1) return 32'd0;
      if (s == N_IN + 2) return 32'd1;
      return words[0];
   endfunction

   task automatic check_state();
      chk("in_ready",  {63'd0, bus.in_ready},  {63'd0, (reset === 1'b1) && (q.size() < 2)});
      chk("out_valid", {63'd0, bus.out_valid}, {63'd0, q.size() > 0});
      if (q.size() > 0) begin
         chk("out_data", 64'(bus.out_data), 64'(q[0].d));
         chk("out_sel",  64'(bus.out_sel),  64'(q[0].s));
`ifdef WB_SELECT_PARITY_EN
         chk("out_par",  64'(bus.out_par),  64'(^q[0].d));
`endif
      end
      if (reset === 1'b0) begin
         chk("rst_out_data", 64'(bus.out_data), 64'd0);
         chk("rst_out_sel",  64'(bus.out_sel),  64'd0);
      end
      chk("sel_err",  64'(bus.sel_err),  64'(m_err));
      chk("wb_count", 64'(bus.wb_count), 64'(m_cnt));
   endtask

   // One clock: drive inputs, advance model, compare after the edge
   task automatic step(input bit iv, input int s, input bit ordy, input bit clr);
      bit   acc;
      bit   fire;
      ent_t e;
      for (int k = 0; k < N_IN; k++) words[k] = $urandom;
      if (ov_k >= 0) words[ov_k] = ov_v;
      ov_k = -1;
      for (int k = 0; k < N_IN; k++) bus.data_in[k*WIDTH +: WIDTH] = words[k];
      bus.in_valid  = iv;
      bus.sel       = SEL_W'(s);
      bus.out_ready = ordy;
      bus.clr_err   = clr;
      acc  = iv && (reset === 1'b1) && (q.size() < 2);
      fire = (q.size() > 0) && ordy;
      e.d  = ref_word(s);
      e.s  = SEL_W'(s);
      @(posedge clk);
      #1;
      if (reset === 1'b0) begin
         q.delete();
         m_err = 1'b0;
         m_cnt = 0;
      end else begin
         if (fire) begin
            void'(q.pop_front());
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
         end
         if (acc) q.push_back(e);
         if (acc && s >= N_IN + 3) m_err = 1'b1;
         else if (clr)             m_err = 1'b0;
      end
      check_state();
   endtask

   initial begin
      reset         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.sel       = '0;
      bus.data_in   = '0;
      bus.out_ready = 1'b0;
      bus.clr_err   = 1'b0;
      m_err         = 1'b0;
      m_cnt         = 0;

      // Reset for two cycles, then release
      step(0, 0, 0, 0);
      step(1, 3, 1, 0);
      reset = 1'b1;
      #1;
      chk("in_ready_after_release", {63'd0, bus.in_ready}, 64'd1);

      // Single word through selector 3
      ov_k = 3; ov_v = 32'hDEADBEEF;
      step(1, 3, 1, 0);
      chk("single_data", 64'(bus.out_data), 64'hDEADBEEF);
      chk("single_sel",  64'(bus.out_sel),  64'd3);
      step(0, 0, 1, 0);
      chk("single_count", 64'(bus.wb_count), 64'd1);

      // Constant slots back-to-back
      step(1, 8, 1, 0);
      chk("const0", 64'(bus.out_data), 64'd227);
      step(1, 9, 1, 0);
      chk("const1", 64'(bus.out_data), 64'd0);
      step(1, 10, 1, 0);
      chk("const2", 64'(bus.out_data), 64'd1);
      chk("const_no_err", 64'(bus.sel_err), 64'd0);
      step(0, 0, 1, 0);

      // Backpressure fills output then skid
      ov_k = 0; ov_v = 32'h11;
      step(1, 0, 0, 0);
      ov_k = 1; ov_v = 32'h22;
      step(1, 1, 0, 0);
      chk("bp_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
      chk("bp_hold_data", 64'(bus.out_data), 64'h11);
      step(1, 2, 0, 0);
      chk("bp_stable_data", 64'(bus.out_data), 64'h11);
      step(0, 0, 1, 0);
      chk("bp_second", 64'(bus.out_data), 64'h22);
      chk("bp_in_ready_back", {63'd0, bus.in_ready}, 64'd1);
      step(0, 0, 1, 0);

      // Illegal selector handling
      ov_k = 0; ov_v = 32'hCAFE0000;
      step(1, 11, 1, 0);
      chk("illegal_word0", 64'(bus.out_data), 64'hCAFE0000);
      chk("illegal_err",   64'(bus.sel_err),  64'd1);
      step(1, 15, 1, 1);
      chk("set_beats_clr", 64'(bus.sel_err),  64'd1);
      step(0, 0, 1, 1);
      chk("clr_alone",     64'(bus.sel_err),  64'd0);
      step(0, 12, 1, 0);
      chk("illegal_no_accept", 64'(bus.sel_err), 64'd0);

      // Counter wrap: 17 transfers from zero
      reset = 1'b0;
      step(0, 0, 0, 0);
      reset = 1'b1;
      for (int i = 0; i < 17; i++) step(1, $urandom_range(0, 10), 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      chk("count_wrap", 64'(bus.wb_count), 64'd1);

      // Reset with both stages full discards them
      step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      chk("full_in_ready", {63'd0, bus.in_ready}, 64'd0);
      reset = 1'b0;
      step(0, 0, 0, 0);
      chk("rst_mid_valid", {63'd0, bus.out_valid}, 64'd0);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 0);
         chk("skid_discarded", {63'd0, bus.out_valid}, 64'd0);
      end

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 4) != 0, $urandom_range(0, 15), ($urandom % 3) != 0, ($urandom % 8) == 0);
      end
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/wb_select_buf.md
Name: wb_select_buf

Overview:
- Write-back source selector for the multicycle datapath.
- Chooses one of N_IN data words or one of three constant slots, then buffers the result in a 2-entry valid/ready pipeline (output register plus skid register) in front of the register-file write port.
- Generalises the plain write-back mux with parametrised width, input count and constants.
- Adds flow control, illegal-select detection and a write-back transfer counter.

Parameters:
- WIDTH, 32, data word width.
- N_IN, 8, number of data inputs; selector codes 0..N_IN-1.
- SEL_W, 4, selector width; must satisfy 2^SEL_W >= N_IN+3.
- CONST0, 227, value for selector code N_IN.
- CONST1, 0, value for selector code N_IN+1.
- CONST2, 1, value for selector code N_IN+2.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  producer offers a select/data set.
- in_ready  out  1  block can accept this cycle.
- sel  in  SEL_W  source selector.
- data_in  in  N_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  1  out_data holds a pending word.
- out_ready  in  1  consumer takes the word.
- out_data  out  WIDTH  selected word.
- out_sel  out  SEL_W  selector that produced out_data.
- sel_err  out  1  sticky illegal-selector flag.
- clr_err  in  1  clears sel_err.
- wb_count  out  CNT_W  count of completed output transfers.

Behaviour:
- Reset is sampled at the clock edge while reset==0. On reset: out_valid=0, out_data=0, out_sel=0, skid empty, sel_err=0, wb_count=0. in_ready=0 while reset is asserted. Reset mid-operation discards both buffered words.
- Decode at accept time (in_valid && in_ready):
  - sel<N_IN: data_in word sel.
  - sel==N_IN: CONST0.
  - sel==N_IN+1: CONST1.
  - sel==N_IN+2: CONST2.
  - sel>=N_IN+3: word 0 is forwarded and sel_err is set.
- Constants are zero-extended or truncated to WIDTH.
- in_ready = !skid_valid, derived from a register with no combinational path from out_ready.
- Accept with output stage empty, or with output full and out_ready=1: the word loads the output register; out_valid=1 next cycle. Latency is 1 cycle.
- Accept with output full and out_ready=0: the word loads the skid register; in_ready=0 next cycle.
- Skid full and out_ready=1: the skid word moves to the output register, skid clears, in_ready=1 next cycle.
- Ordering is strictly FIFO. No word is dropped or duplicated.
- out_data and out_sel stay stable while out_valid=1 and out_ready=0.
- out_ready with out_valid=0 has no effect.
- wb_count increments on each out_valid && out_ready and wraps modulo 2^CNT_W.
- sel_err sets on an accepted illegal selector. clr_err clears it. If set and clear occur in the same cycle, set wins. An illegal sel without acceptance has no effect.

Optional Feature:
- Macro: WB_SELECT_PARITY_EN.
- Defined: adds output port out_par (1 bit) = XOR-reduction of out_data, registered alongside out_data. Reset value 0.
- Undefined: the port and its logic are absent.

Test Plan:
- Reset: reset=0 for 2 cycles, then reset=1 -> out_valid=0, out_data=0, wb_count=0, sel_err=0; in_ready=1 on the first cycle after release.
- Single word: in_valid=1, sel=3, data_in word3=0xDEADBEEF, out_ready=1 -> next cycle out_valid=1, out_data=0xDEADBEEF, out_sel=3; wb_count=1 after the transfer.
- Constants: sel=8,9,10 back-to-back with out_ready=1 -> out_data sequence 227, 0, 1; sel_err stays 0.
- Backpressure: out_ready=0, send sel=0 (0x11) then sel=1 (0x22) -> in_ready=0 after the second accept. Raise out_ready -> outputs 0x11 then 0x22 in order; in_ready returns to 1.
- Illegal select: sel=11 accepted -> out_data = data_in word0, sel_err=1. Assert clr_err together with another sel=15 accept -> sel_err stays 1. Assert clr_err alone -> sel_err=0.
- Counter wrap with CNT_W=4: 17 transfers -> wb_count=1. Reset asserted with both stages full -> out_valid=0 next cycle and the skid contents are never emitted.
